// File: rtl/sink_flow_control_responder.sv
// Consumer-side flow-control responder: passes a CHDR stream straight through, counts
// consumed data packets and returns credit as 2-line flow-control packets.

module setting_reg #(
   parameter logic [7:0]       ADDR     = 8'd0,
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] AT_RESET = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic [7:0]       addr,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] value
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         value <= AT_RESET;
      else if (strobe && addr == ADDR)
         value <= data;
   end
endmodule

module sink_flow_control_responder #(
   parameter logic [7:0] SR_FC_EN     = 8'd0,
   parameter logic [7:0] SR_FC_PKTS   = 8'd1,
   parameter logic [7:0] SR_FC_CYCLES = 8'd2,
   parameter logic [7:0] SR_FC_SID    = 8'd3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [63:0] in_tdata,
   input  logic        in_tlast,
   input  logic        in_tvalid,
   output logic        in_tready,
   output logic [63:0] out_tdata,
   output logic        out_tlast,
   output logic        out_tvalid,
   input  logic        out_tready,
   output logic [63:0] fc_tdata,
   output logic        fc_tlast,
   output logic        fc_tvalid,
   input  logic        fc_tready,
   output logic        busy,
   output logic [31:0] debug
);
   typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2} state_t;

   state_t      state, state_next;
   logic        enable;
   logic [15:0] thresh;
   logic [31:0] cyc_thresh;
   logic [31:0] sid;

   logic [31:0] consumed;
   logic [15:0] pkt_cnt;
   logic [31:0] cyc_cnt;
   logic [11:0] fc_seq;
   logic [11:0] seq_snap;
   logic [31:0] snap;
   logic        first_line;
   logic        is_data_reg;
   logic        resync_pend;

   logic        xfer, is_data_now, is_data_cur, done, resync;
   logic [15:0] thresh_eff;
   logic        trigger, start, finish;

   setting_reg #(.ADDR(SR_FC_EN), .WIDTH(1), .AT_RESET(1'b0)) u_sr_en (
      .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
      .data(set_data[0]), .value(enable));

   setting_reg #(.ADDR(SR_FC_PKTS), .WIDTH(16), .AT_RESET(16'd0)) u_sr_pkts (
      .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
      .data(set_data[15:0]), .value(thresh));

   setting_reg #(.ADDR(SR_FC_CYCLES), .WIDTH(32), .AT_RESET(32'd0)) u_sr_cycles (
      .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
      .data(set_data), .value(cyc_thresh));

   setting_reg #(.ADDR(SR_FC_SID), .WIDTH(32), .AT_RESET(32'd0)) u_sr_sid (
      .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
      .data(set_data), .value(sid));

   // Zero-latency passthrough; the FC port never back-pressures the data path.
   assign out_tdata  = in_tdata;
   assign out_tlast  = in_tlast;
   assign out_tvalid = in_tvalid;
   assign in_tready  = out_tready;

   assign xfer        = in_tvalid & out_tready;
   assign is_data_now = (in_tdata[63:62] == 2'b00);
   assign is_data_cur = first_line ? is_data_now : is_data_reg;
   assign done        = xfer & in_tlast & is_data_cur;
   assign resync      = clear | (set_stb & (set_addr == SR_FC_EN));

   assign thresh_eff = (thresh == 16'd0) ? 16'd1 : thresh;
   assign trigger    = enable & ~resync &
                       ((pkt_cnt >= thresh_eff) |
                        ((cyc_thresh != 32'd0) & (pkt_cnt != 16'd0) & (cyc_cnt >= cyc_thresh)));

   always_comb begin
      state_next = state;
      fc_tvalid  = 1'b0;
      fc_tlast   = 1'b0;
      fc_tdata   = 64'd0;
      start      = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_next = HEAD;
               start      = 1'b1;
            end
         end
         HEAD: begin
            fc_tvalid = 1'b1;
            fc_tdata  = {2'b01, 1'b0, 1'b0, seq_snap, 16'd16, sid};
            if (fc_tready)
               state_next = BODY;
         end
         BODY: begin
            fc_tvalid = 1'b1;
            fc_tlast  = 1'b1;
            fc_tdata  = {32'd0, snap};
            if (fc_tready) begin
               state_next = IDLE;
               finish     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         consumed    <= 32'hFFFF_FFFF;
         pkt_cnt     <= 16'd0;
         cyc_cnt     <= 32'd0;
         fc_seq      <= 12'd0;
         seq_snap    <= 12'd0;
         snap        <= 32'd0;
         first_line  <= 1'b1;
         is_data_reg <= 1'b0;
         resync_pend <= 1'b0;
      end else begin
         state <= state_next;

         if (xfer) begin
            if (in_tlast)
               first_line <= 1'b1;
            else if (first_line)
               first_line <= 1'b0;
            if (first_line)
               is_data_reg <= is_data_now;
         end

         if (start) begin
            snap     <= consumed;
            seq_snap <= fc_seq;
         end

         // A resync while a packet is in flight must still keep fc_seq at 0
         // once that packet completes.
         if (finish)
            resync_pend <= 1'b0;
         else if (resync && state != IDLE)
            resync_pend <= 1'b1;

         if (resync) begin
            consumed   <= 32'hFFFF_FFFF;
            pkt_cnt    <= 16'd0;
            cyc_cnt    <= 32'd0;
            first_line <= 1'b1;
            fc_seq     <= 12'd0;
         end else begin
            if (done)
               consumed <= consumed + 32'd1;

            if (start) begin
               pkt_cnt <= done ? 16'd1 : 16'd0;
               cyc_cnt <= 32'd0;
            end else begin
               if (done && pkt_cnt != 16'hFFFF)
                  pkt_cnt <= pkt_cnt + 16'd1;
               if (state == IDLE && pkt_cnt != 16'd0) begin
                  if (cyc_cnt != 32'hFFFF_FFFF)
                     cyc_cnt <= cyc_cnt + 32'd1;
               end else begin
                  cyc_cnt <= 32'd0;
               end
            end

            if (finish && !resync_pend)
               fc_seq <= fc_seq + 12'd1;
         end
      end
   end

   assign busy  = (state != IDLE);
   assign debug = {enable, state, pkt_cnt[4:0], fc_seq, consumed[11:0]};

endmodule
